if_layer_refrac_controller: RTL and testbench

Parametrised per-neuron spike/reset controller for an integrate-and-fire layer. It takes raw threshold crossings from `NUM_NEURONS` IF neurons and issues a one-cycle membrane reset per accepted spike. It enforces a programmable refractory period per neuron with a dedicated down-counter, and optionally applies winner-take-all lateral inhibition across the layer. It sits between the neuron array and the downstream spike consumer.

---
 rtl/if_layer_pkg.sv | 15 +
 rtl/refrac_counter.sv | 33 +++
 rtl/if_layer_refrac_controller.sv | 91 +++++++++
 tb/tb_if_layer_refrac_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/if_layer_pkg.sv
// rtl/if_layer_pkg.sv - shared types and helpers for the IF layer refractory controller
package if_layer_pkg;

    typedef enum logic {
        INH_NONE = 1'b0,
        INH_WTA  = 1'b1
    } inhibit_mode_e;

    localparam int DEFAULT_REFRAC = 5;

    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/refrac_counter.sv
// rtl/refrac_counter.sv - per-neuron refractory down-counter, busy while nonzero
module refrac_counter
    import if_layer_pkg::*;
#(
    parameter int REFRAC = DEFAULT_REFRAC,
    parameter int CNT_W  = clog2_min1(REFRAC + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(REFRAC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (load) begin
                cnt <= LOAD_VAL;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/if_layer_refrac_controller.sv
// rtl/if_layer_refrac_controller.sv - spike acceptance, refractory gating and optional WTA inhibition
module if_layer_refrac_controller
    import if_layer_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int REFRAC      = 5,
    parameter int INHIBIT     = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       en,
    input  logic [NUM_NEURONS-1:0]                     spike_in,
    output logic [NUM_NEURONS-1:0]                     neuron_rst,
    output logic [NUM_NEURONS-1:0]                     neuron_en,
    output logic [NUM_NEURONS-1:0]                     spike_out,
    output logic                                       winner_valid,
    output logic [clog2_min1(NUM_NEURONS)-1:0]         winner_idx
);

    localparam int            CNT_W = clog2_min1(REFRAC + 1);
    localparam int            IDX_W = clog2_min1(NUM_NEURONS);
    localparam inhibit_mode_e MODE  = (INHIBIT != 0) ? INH_WTA : INH_NONE;

    logic [NUM_NEURONS-1:0] busy;
    logic [NUM_NEURONS-1:0] cand;
    logic [NUM_NEURONS-1:0] win_onehot;
    logic [NUM_NEURONS-1:0] load;
    logic [NUM_NEURONS-1:0] spike_next;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_cand;
    logic                   wta_fire;

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_cnt
            refrac_counter #(
                .REFRAC (REFRAC),
                .CNT_W  (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .load  (load[g]),
                .busy  (busy[g])
            );
        end
    endgenerate

    assign neuron_en = ~busy;
    assign cand      = {NUM_NEURONS{en}} & spike_in & ~busy;
    assign any_cand  = |cand;

    // Scan high to low so the last hit, i.e. the lowest index, wins.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx    = IDX_W'(i);
                win_onehot = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Under WTA any acceptance resets and silences the whole layer, refractory neurons included.
    assign wta_fire   = (MODE == INH_WTA) && any_cand;
    assign load       = wta_fire ? {NUM_NEURONS{1'b1}} : cand;
    assign spike_next = wta_fire ? win_onehot : cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neuron_rst   <= {NUM_NEURONS{1'b1}};
            spike_out    <= '0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
        end else if (en) begin
            neuron_rst   <= load;
            spike_out    <= spike_next;
            winner_valid <= any_cand;
            if (any_cand) begin
                winner_idx <= win_idx;
            end
        end else begin
            neuron_rst   <= '0;
            spike_out    <= '0;
            winner_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_layer_refrac_controller.sv
// tb/tb_if_layer_refrac_controller.sv - self-checking bench for three controller configurations
module tb_if_layer_refrac_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] spike_in;

    logic [3:0] rst0, nen0, spk0, rst1, nen1, spk1, rst2, nen2, spk2;
    logic       wv0, wv1, wv2;
    logic [1:0] idx0, idx1, idx2;

    always #5 clk = ~clk;

    if_layer_refrac_controller #(.NUM_NEURONS(4), .REFRAC(3), .INHIBIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .neuron_rst(rst0), .neuron_en(nen0), .spike_out(spk0),
        .winner_valid(wv0), .winner_idx(idx0)
    );

    if_layer_refrac_controller #(.NUM_NEURONS(4), .REFRAC(3), .INHIBIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .neuron_rst(rst1), .neuron_en(nen1), .spike_out(spk1),
        .winner_valid(wv1), .winner_idx(idx1)
    );

    if_layer_refrac_controller #(.NUM_NEURONS(4), .REFRAC(0), .INHIBIT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .neuron_rst(rst2), .neuron_en(nen2), .spike_out(spk2),
        .winner_valid(wv2), .winner_idx(idx2)
    );

    typedef struct {
        logic       en;
        logic [3:0] din;
        logic [3:0] s0, r0, n0;
        logic       v0;
        logic [1:0] i0;
        logic [3:0] s1, r1, n1;
        logic       v1;
        logic [1:0] i1;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];
    vec_t sb_q [$];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic e, input logic [3:0] d,
                                input logic [3:0] s0, input logic [3:0] r0, input logic [3:0] n0,
                                input logic v0, input logic [1:0] i0,
                                input logic [3:0] s1, input logic [3:0] r1, input logic [3:0] n1,
                                input logic v1, input logic [1:0] i1);
        vec_t v;
        v.en = e; v.din = d;
        v.s0 = s0; v.r0 = r0; v.n0 = n0; v.v0 = v0; v.i0 = i0;
        v.s1 = s1; v.r1 = r1; v.n1 = n1; v.v1 = v1; v.i1 = i1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] d);
        @(negedge clk);
        en       = e;
        spike_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // step A..Q: test 2 (neuron 1 refractory), test 3 (en gating on neuron 2), test 4 (WTA)
        tbl[0]  = mk(1, 4'b0010, 4'b0010, 4'b0010, 4'b1101, 1, 1, 4'b0010, 4'b1111, 4'b0000, 1, 1);
        tbl[1]  = mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[2]  = mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[3]  = mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1);
        tbl[4]  = mk(1, 4'b0010, 4'b0010, 4'b0010, 4'b1101, 1, 1, 4'b0010, 4'b1111, 4'b0000, 1, 1);
        tbl[5]  = mk(1, 4'b0100, 4'b0100, 4'b0100, 4'b1001, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[6]  = mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b1001, 0, 2, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[7]  = mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b1001, 0, 2, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[8]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 0, 2, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[9]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 0, 2, 4'b0000, 4'b0000, 4'b1111, 0, 1);
        tbl[10] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 2, 4'b0000, 4'b0000, 4'b1111, 0, 1);
        tbl[11] = mk(1, 4'b1010, 4'b1010, 4'b1010, 4'b0101, 1, 1, 4'b0010, 4'b1111, 4'b0000, 1, 1);
        tbl[12] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[13] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[14] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1);
        tbl[15] = mk(1, 4'b1100, 4'b1100, 4'b1100, 4'b0011, 1, 2, 4'b0100, 4'b1111, 4'b0000, 1, 2);
        tbl[16] = mk(0, 4'b1000, 4'b0000, 4'b0000, 4'b0011, 0, 2, 4'b0000, 4'b0000, 4'b0000, 0, 2);

        // test 1: reset with all spikes high
        rst_n    = 1'b0;
        en       = 1'b1;
        spike_in = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst0", 32'(rst0), 32'hf);
        chk("reset_rst1", 32'(rst1), 32'hf);
        chk("reset_spk0", 32'(spk0), 32'h0);
        chk("reset_wv0", 32'(wv0), 32'h0);
        chk("reset_idx0", 32'(idx0), 32'h0);
        chk("reset_nen0", 32'(nen0), 32'hf);
        chk("reset_nen1", 32'(nen1), 32'hf);

        @(negedge clk);
        rst_n    = 1'b1;
        spike_in = 4'b0000;
        @(posedge clk);
        #1;
        chk("release_rst0", 32'(rst0), 32'h0);
        chk("release_rst1", 32'(rst1), 32'h0);
        chk("release_spk0", 32'(spk0), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            vec_t exp;
            sb_q.push_back(tbl[i]);
            drive(tbl[i].en, tbl[i].din);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty at vector %0d", i);
            end else begin
                exp = sb_q.pop_front();
                chk($sformatf("v%0d_spk0", i), 32'(spk0), 32'(exp.s0));
                chk($sformatf("v%0d_rst0", i), 32'(rst0), 32'(exp.r0));
                chk($sformatf("v%0d_nen0", i), 32'(nen0), 32'(exp.n0));
                chk($sformatf("v%0d_wv0", i), 32'(wv0), 32'(exp.v0));
                chk($sformatf("v%0d_idx0", i), 32'(idx0), 32'(exp.i0));
                chk($sformatf("v%0d_spk1", i), 32'(spk1), 32'(exp.s1));
                chk($sformatf("v%0d_rst1", i), 32'(rst1), 32'(exp.r1));
                chk($sformatf("v%0d_nen1", i), 32'(nen1), 32'(exp.n1));
                chk($sformatf("v%0d_wv1", i), 32'(wv1), 32'(exp.v1));
                chk($sformatf("v%0d_idx1", i), 32'(idx1), 32'(exp.i1));
            end
        end

        // test 6: reset while neuron 3 of dut0 has cnt=2
        drive(1'b1, 4'b0000);
        chk("pre_rst_nen0", 32'(nen0), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_nen0", 32'(nen0), 32'hf);
        chk("async_rst_rst0", 32'(rst0), 32'hf);
        chk("async_rst_nen1", 32'(nen1), 32'hf);
        @(negedge clk);
        rst_n    = 1'b1;
        en       = 1'b1;
        spike_in = 4'b1000;
        @(posedge clk);
        #1;
        chk("post_rst_spk0", 32'(spk0), 32'h8);
        chk("post_rst_rst0", 32'(rst0), 32'h8);
        chk("post_rst_nen0", 32'(nen0), 32'h7);
        chk("post_rst_spk1", 32'(spk1), 32'h8);
        chk("post_rst_rst1", 32'(rst1), 32'hf);
        chk("post_rst_idx1", 32'(idx1), 32'h3);
        chk("post_rst_wv1", 32'(wv1), 32'h1);

        // test 5: REFRAC=0 accepts every step
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 4'b0001);
            chk($sformatf("r0_step%0d_spk2", s), 32'(spk2), 32'h1);
            chk($sformatf("r0_step%0d_rst2", s), 32'(rst2), 32'h1);
            chk($sformatf("r0_step%0d_nen2", s), 32'(nen2), 32'hf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
